// File: rtl/legv8_pkg.sv
// legv8_pkg: shared types, widths and helpers for the LEGv8 fetch path.
//   pc_state_t   : sequencer state (IDLE, RUN, HALT)
//   PC_W         : program-counter / word-index width
//   RETIRE_W     : retired-instruction counter width
//   sext_imm26() : sign-extend a B-type word offset to PC_W bits
//   sext_imm19() : sign-extend a conditional-branch word offset to PC_W bits
package legv8_pkg;

  localparam int unsigned PC_W     = 64;
  localparam int unsigned RETIRE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } pc_state_t;

  function automatic logic [PC_W-1:0] sext_imm26(input logic [25:0] imm);
    return {{(PC_W-26){imm[25]}}, imm};
  endfunction

  function automatic logic [PC_W-1:0] sext_imm19(input logic [18:0] imm);
    return {{(PC_W-19){imm[18]}}, imm};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-word-index selection and range check.
//   counter       : current word index
//   br_reg        : BR, target = reg_target >> 2 (highest priority)
//   br_uncond     : B/BL, target = counter + sext(imm26)
//   br_cond_taken : taken conditional, target = counter + sext(imm19)
//   (none)        : sequential, target = counter + 1
//   next_idx      : selected target (all sums modulo 2^64)
//   range_err     : selected target, unsigned, is >= ROM_DEPTH
module next_pc_calc
  import legv8_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 32
) (
  input  logic [PC_W-1:0] counter,
  input  logic            br_reg,
  input  logic            br_uncond,
  input  logic            br_cond_taken,
  input  logic [25:0]     imm26,
  input  logic [18:0]     imm19,
  input  logic [PC_W-1:0] reg_target,
  output logic [PC_W-1:0] next_idx,
  output logic            range_err
);

  logic [PC_W-1:0] target;

  always_comb begin
    target = counter + PC_W'(1);
    if (br_reg) begin
      target = reg_target >> 2;
    end else if (br_uncond) begin
      target = counter + sext_imm26(imm26);
    end else if (br_cond_taken) begin
      target = counter + sext_imm19(imm19);
    end
    next_idx  = target;
    // Unsigned compare also catches negative offsets that wrapped.
    range_err = (target >= PC_W'(ROM_DEPTH));
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch sequencer for the single-cycle LEGv8.
//   clock, reset_n  : clock (posedge) and asynchronous active-low reset
//   start           : IDLE/HALT -> RUN, reloads RESET_PC, clears counters
//   stall           : hold everything this cycle (RUN only)
//   halt_req        : HALT decoded at the current PC
//   br_uncond, br_cond_taken, br_reg, imm26, imm19, reg_target : branch controls
//   counter         : current word index into the instruction ROM
//   running, halted : registered state flags
//   out_of_range    : sticky, HALT entered because the target was invalid
//   retired         : saturating count of instructions retired since start
module pc_sequencer
  import legv8_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 32,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stall,
  input  logic                halt_req,
  input  logic                br_uncond,
  input  logic                br_cond_taken,
  input  logic                br_reg,
  input  logic [25:0]         imm26,
  input  logic [18:0]         imm19,
  input  logic [PC_W-1:0]     reg_target,
  output logic [PC_W-1:0]     counter,
  output logic                running,
  output logic                halted,
  output logic                out_of_range,
  output logic [RETIRE_W-1:0] retired
);

  pc_state_t       state;
  logic [PC_W-1:0] next_idx;
  logic            range_err;

  next_pc_calc #(
    .ROM_DEPTH(ROM_DEPTH)
  ) u_next_pc_calc (
    .counter      (counter),
    .br_reg       (br_reg),
    .br_uncond    (br_uncond),
    .br_cond_taken(br_cond_taken),
    .imm26        (imm26),
    .imm19        (imm19),
    .reg_target   (reg_target),
    .next_idx     (next_idx),
    .range_err    (range_err)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      counter      <= PC_W'(RESET_PC);
      retired      <= '0;
      out_of_range <= 1'b0;
      running      <= 1'b0;
      halted       <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state        <= RUN;
            counter      <= PC_W'(RESET_PC);
            retired      <= '0;
            out_of_range <= 1'b0;
            running      <= 1'b1;
            halted       <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            // The halting cycle still retires an instruction.
            if (retired != '1) begin
              retired <= retired + RETIRE_W'(1);
            end
            if (halt_req) begin
              state   <= HALT;
              running <= 1'b0;
              halted  <= 1'b1;
            end else if (range_err) begin
              state        <= HALT;
              running      <= 1'b0;
              halted       <= 1'b1;
              out_of_range <= 1'b1;
            end else begin
              counter <= next_idx;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned RPC   = 0;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, stall, halt_req, br_uncond, br_cond_taken, br_reg;
  logic [25:0] imm26;
  logic [18:0] imm19;
  logic [63:0] reg_target;
  logic [63:0] counter;
  logic        running, halted, out_of_range;
  logic [31:0] retired;

  always #5 clock = ~clock;

  pc_sequencer #(
    .ROM_DEPTH(DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .stall        (stall),
    .halt_req     (halt_req),
    .br_uncond    (br_uncond),
    .br_cond_taken(br_cond_taken),
    .br_reg       (br_reg),
    .imm26        (imm26),
    .imm19        (imm19),
    .reg_target   (reg_target),
    .counter      (counter),
    .running      (running),
    .halted       (halted),
    .out_of_range (out_of_range),
    .retired      (retired)
  );

  int checks = 0;
  int errors = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: architectural rules of the sequencer.
  bit              m_run, m_halt, m_oor;
  longint unsigned m_pc, m_ret;

  function automatic void model_reset();
    m_run = 0; m_halt = 0; m_oor = 0; m_pc = RPC; m_ret = 0;
  endfunction

  function automatic void model_step();
    longint unsigned t;
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_halt = 0; m_oor = 0; m_pc = RPC; m_ret = 0;
      end
    end else if (!stall) begin
      if (m_ret < 64'hFFFF_FFFF) m_ret = m_ret + 1;
      if (br_reg)             t = reg_target / 4;
      else if (br_uncond)     t = m_pc + longint'($signed(imm26));
      else if (br_cond_taken) t = m_pc + longint'($signed(imm19));
      else                    t = m_pc + 1;
      if (halt_req) begin
        m_run = 0; m_halt = 1;
      end else if (t >= DEPTH) begin
        m_run = 0; m_halt = 1; m_oor = 1;
      end else begin
        m_pc = t;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    check64({tag, ".counter"}, counter, m_pc);
    check64({tag, ".running"}, 64'(running), 64'(m_run));
    check64({tag, ".halted"}, 64'(halted), 64'(m_halt));
    check64({tag, ".oor"}, 64'(out_of_range), 64'(m_oor));
    check64({tag, ".retired"}, 64'(retired), m_ret);
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; halt_req = 0; br_uncond = 0; br_cond_taken = 0; br_reg = 0;
    imm26 = '0; imm19 = '0; reg_target = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  typedef struct {
    logic        st, sl, hr, bu, bc, br;
    logic [25:0] i26;
    logic [18:0] i19;
    logic [63:0] rt;
    logic [63:0] e_cnt;
    logic        e_run, e_halt, e_oor;
    logic [31:0] e_ret;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic sl, logic hr, logic bu, logic bc, logic br,
                              logic [25:0] i26, logic [18:0] i19, logic [63:0] rt,
                              logic [63:0] e_cnt, logic e_run, logic e_halt, logic e_oor,
                              logic [31:0] e_ret);
    vec_t v;
    v.st = st; v.sl = sl; v.hr = hr; v.bu = bu; v.bc = bc; v.br = br;
    v.i26 = i26; v.i19 = i19; v.rt = rt;
    v.e_cnt = e_cnt; v.e_run = e_run; v.e_halt = e_halt; v.e_oor = e_oor; v.e_ret = e_ret;
    return v;
  endfunction

  initial begin
    reset_n = 0;
    do_reset();

    // Reset state
    check64("rst.counter", counter, 64'(RPC));
    check64("rst.running", 64'(running), 64'd0);
    check64("rst.halted", 64'(halted), 64'd0);
    check64("rst.oor", 64'(out_of_range), 64'd0);
    check64("rst.retired", 64'(retired), 64'd0);

    //            st sl hr bu bc br imm26      imm19     rt      cnt run hlt oor ret
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 26'd0,     19'd0,    64'd0,   0, 1, 0, 0, 0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 26'd0,   19'd0,    64'd0,   64'(i), 1, 0, 0, 32'(i)));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 26'(-1),   19'd0,    64'd0,   4, 1, 0, 0, 6));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 26'(-3),   19'd7,    64'd0,   1, 1, 0, 0, 7));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 26'd0,     19'd5,    64'd0,   6, 1, 0, 0, 8));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 1, 1, 1, 1, 26'd9,   19'd9,    64'h28,  6, 1, 0, 0, 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 26'd0,     19'd0,    64'h28,  10, 1, 0, 0, 9));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 26'd5,     19'd0,    64'h0F,  3, 1, 0, 0, 10));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 26'd2,     19'd0,    64'd0,   3, 0, 1, 0, 11));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 26'd2,     19'd0,    64'd0,   3, 0, 1, 0, 11));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 26'd0,     19'd0,    64'd0,   0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 26'd0,     19'd0,    64'd124, 31, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 26'd0,     19'd0,    64'd0,   31, 0, 1, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 26'd0,     19'd0,    64'd0,   0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 26'd4,     19'd0,    64'd0,   0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 26'd0,     19'd0,    64'd0,   1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 26'd0,     19'(-2),  64'd0,   1, 0, 1, 1, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 26'd0,     19'd0,    64'd0,   0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 26'd31,    19'd0,    64'd0,   31, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 26'd1,     19'd0,    64'd0,   31, 0, 1, 1, 2));

    foreach (tbl[i]) begin
      start = tbl[i].st; stall = tbl[i].sl; halt_req = tbl[i].hr;
      br_uncond = tbl[i].bu; br_cond_taken = tbl[i].bc; br_reg = tbl[i].br;
      imm26 = tbl[i].i26; imm19 = tbl[i].i19; reg_target = tbl[i].rt;
      tick();
      check64($sformatf("vec%0d.counter", i), counter, tbl[i].e_cnt);
      check64($sformatf("vec%0d.running", i), 64'(running), 64'(tbl[i].e_run));
      check64($sformatf("vec%0d.halted", i), 64'(halted), 64'(tbl[i].e_halt));
      check64($sformatf("vec%0d.oor", i), 64'(out_of_range), 64'(tbl[i].e_oor));
      check64($sformatf("vec%0d.retired", i), 64'(retired), 64'(tbl[i].e_ret));
    end

    // Asynchronous reset mid-cycle at counter 9
    clear_inputs();
    start = 1; tick();
    start = 0; br_reg = 1; reg_target = 64'h24; tick();
    check64("arst.pre_counter", counter, 64'd9);
    clear_inputs();
    @(negedge clock);
    #2;
    reset_n = 0;
    #1;
    model_reset();
    check64("arst.counter", counter, 64'(RPC));
    check64("arst.running", 64'(running), 64'd0);
    check64("arst.retired", 64'(retired), 64'd0);
    @(negedge clock);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      br_uncond = 1; imm26 = 26'd5; tick();
      check64($sformatf("idle%0d.counter", i), counter, 64'(RPC));
      check64($sformatf("idle%0d.running", i), 64'(running), 64'd0);
    end

    // Randomized run against the reference model
    do_reset();
    check_model("rnd_rst");
    for (int n = 0; n < 1500; n++) begin
      start         = ($urandom_range(0, 9) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      halt_req      = ($urandom_range(0, 24) == 0);
      br_reg        = ($urandom_range(0, 5) == 0);
      br_uncond     = ($urandom_range(0, 3) == 0);
      br_cond_taken = ($urandom_range(0, 3) == 0);
      imm26 = 26'($urandom_range(0, 20)) - 26'd10;
      imm19 = 19'($urandom_range(0, 20)) - 19'd10;
      if ($urandom_range(0, 30) == 0) imm26 = 26'($urandom);
      reg_target = 64'($urandom_range(0, 150));
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
